// File: rtl/hazard_ctrl_p.sv
// Parametrised hazard controller for the 5-stage pipeline: PC/latch enables and flushes,
// a dcache-wait/halt state machine and saturating stall/flush counters.
module hazard_ctrl_p #(
  parameter int REGW     = 5,
  parameter int FWD_EN   = 1,
  parameter int BR_STAGE = 3,
  parameter int CNTW     = 16
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            dmemreq,
  input  logic            halt,
  input  logic [REGW-1:0] id_rs,
  input  logic [REGW-1:0] id_rt,
  input  logic [REGW-1:0] ex_rd,
  input  logic [REGW-1:0] mem_rd,
  input  logic            ex_regWEN,
  input  logic            mem_regWEN,
  input  logic            ex_memread,
  input  logic            mispredict,
  output logic            pcen,
  output logic [3:0]      latch_en,
  output logic [3:0]      latch_flush,
  output logic            halted,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, HALTED} state_t;

  // Latches upstream of the branch-resolve stage hold wrong-path work on a mispredict.
  localparam logic [3:0] BR_FLUSH = 4'((1 << BR_STAGE) - 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNTW-1:0] flush_cnt_q, flush_cnt_d;

  logic dmiss;
  logic ex_hit, mem_hit, ex_dep, data_hazard;
  logic flush_event;

  assign dmiss = dmemreq & ~dhit;

  always_comb begin
    ex_hit  = ((id_rs != '0) && (id_rs == ex_rd)) || ((id_rt != '0) && (id_rt == ex_rd));
    mem_hit = ((id_rs != '0) && (id_rs == mem_rd)) || ((id_rt != '0) && (id_rt == mem_rd));
    ex_dep  = (FWD_EN != 0) ? ex_memread : ex_regWEN;
    data_hazard = (ex_hit && ex_dep) || ((FWD_EN == 0) && mem_hit && mem_regWEN);
  end

  always_comb begin
    pcen        = 1'b1;
    latch_en    = 4'hF;
    latch_flush = 4'h0;
    flush_event = 1'b0;
    if (!nRST) begin
      pcen        = 1'b0;
      latch_en    = 4'h0;
      latch_flush = 4'hF;
    end else if (state_q == HALTED) begin
      pcen     = 1'b0;
      latch_en = 4'h0;
    end else if (dmiss) begin
      pcen     = 1'b0;
      latch_en = 4'h0;
    end else if (mispredict) begin
      // PC takes the corrected target even without ihit; the in-flight fetch is flushed.
      latch_flush = BR_FLUSH;
      flush_event = 1'b1;
    end else if (data_hazard) begin
      pcen        = 1'b0;
      latch_en    = 4'b1110;
      latch_flush = 4'b0010;
    end else if (!ihit) begin
      pcen        = 1'b0;
      latch_flush = 4'b0001;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (dmiss)     state_d = MEMWAIT;
        else if (halt) state_d = HALTED;
      end
      MEMWAIT: begin
        if (halt && !dmiss) state_d = HALTED;
        else if (dhit)      state_d = RUN;
      end
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pcen && (state_q != HALTED) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_event && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted    = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// Directed bench for hazard_ctrl_p: one forwarding/BR_STAGE=3 instance and one
// no-forwarding/BR_STAGE=2/CNTW=4 instance share the same stimulus.
module tb_hazard_ctrl_p;

  logic       CLK, nRST;
  logic       ihit, dhit, dmemreq, halt, mispredict;
  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic       ex_regWEN, mem_regWEN, ex_memread;

  logic        pcen_a, halted_a;
  logic [3:0]  en_a, flush_a;
  logic [15:0] stall_a, fcnt_a;
  logic        pcen_b, halted_b;
  logic [3:0]  en_b, flush_b;
  logic [3:0]  stall_b, fcnt_b;

  int compared   = 0;
  int mismatched = 0;

  hazard_ctrl_p #(.REGW(5), .FWD_EN(1), .BR_STAGE(3), .CNTW(16)) dut_a (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemreq(dmemreq), .halt(halt),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .ex_regWEN(ex_regWEN), .mem_regWEN(mem_regWEN), .ex_memread(ex_memread),
    .mispredict(mispredict), .pcen(pcen_a), .latch_en(en_a), .latch_flush(flush_a),
    .halted(halted_a), .stall_cnt(stall_a), .flush_cnt(fcnt_a)
  );

  hazard_ctrl_p #(.REGW(5), .FWD_EN(0), .BR_STAGE(2), .CNTW(4)) dut_b (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmemreq(dmemreq), .halt(halt),
    .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd), .mem_rd(mem_rd),
    .ex_regWEN(ex_regWEN), .mem_regWEN(mem_regWEN), .ex_memread(ex_memread),
    .mispredict(mispredict), .pcen(pcen_b), .latch_en(en_b), .latch_flush(flush_b),
    .halted(halted_b), .stall_cnt(stall_b), .flush_cnt(fcnt_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic i_ihit, input logic i_dhit, input logic i_dmemreq,
                               input logic i_halt, input logic i_mispredict);
    ihit       = i_ihit;
    dhit       = i_dhit;
    dmemreq    = i_dmemreq;
    halt       = i_halt;
    mispredict = i_mispredict;
    #1;
  endtask

  task automatic applyRegs(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] erd,
                           input logic [4:0] mrd, input logic ewen, input logic mwen,
                           input logic emr);
    id_rs      = rs;
    id_rt      = rt;
    ex_rd      = erd;
    mem_rd     = mrd;
    ex_regWEN  = ewen;
    mem_regWEN = mwen;
    ex_memread = emr;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic doReset();
    nRST = 1'b0;
    #1;
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    #1;
  endtask

  initial begin
    nRST = 1'b1;
    applyRegs(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    tick();

    // Reset values while nRST is held low
    nRST = 1'b0;
    #1;
    checkOutput("rst_pcen", 32'(pcen_a), 32'h0);
    checkOutput("rst_en", 32'(en_a), 32'h0);
    checkOutput("rst_flush", 32'(flush_a), 32'hF);
    checkOutput("rst_halted", 32'(halted_a), 32'h0);
    checkOutput("rst_stall", 32'(stall_a), 32'h0);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    #1;
    checkOutput("idle_pcen", 32'(pcen_a), 32'h1);
    checkOutput("idle_en", 32'(en_a), 32'hF);
    checkOutput("idle_flush", 32'(flush_a), 32'h0);

    // Load-use with forwarding: one stall, bubble into ID/EX
    doReset();
    applyRegs(5, 0, 5, 0, 1, 0, 1);
    #1;
    checkOutput("lu_pcen", 32'(pcen_a), 32'h0);
    checkOutput("lu_en", 32'(en_a), 32'b1110);
    checkOutput("lu_flush", 32'(flush_a), 32'b0010);
    tick();
    applyRegs(5, 0, 0, 5, 0, 1, 0);
    #1;
    checkOutput("lu_bubble_pcen", 32'(pcen_a), 32'h1);
    checkOutput("lu_stall_cnt", 32'(stall_a), 32'h1);

    // ALU dependency in EX: forwarding instance runs, non-forwarding one stalls
    applyRegs(5, 0, 5, 0, 1, 0, 0);
    #1;
    checkOutput("alu_fwd_pcen", 32'(pcen_a), 32'h1);
    checkOutput("alu_nofwd_pcen", 32'(pcen_b), 32'h0);

    // Register 0 never hazards, even against a load
    applyRegs(0, 0, 0, 0, 1, 1, 1);
    #1;
    checkOutput("r0_pcen_a", 32'(pcen_a), 32'h1);
    checkOutput("r0_pcen_b", 32'(pcen_b), 32'h1);

    // MEM-stage RAW without forwarding
    applyRegs(0, 7, 0, 7, 0, 1, 0);
    #1;
    checkOutput("mem_nofwd_pcen", 32'(pcen_b), 32'h0);
    checkOutput("mem_nofwd_en", 32'(en_b), 32'b1110);
    checkOutput("mem_fwd_pcen", 32'(pcen_a), 32'h1);
    applyRegs(0, 7, 0, 3, 0, 1, 0);
    #1;
    checkOutput("mem_other_rd_pcen", 32'(pcen_b), 32'h1);
    applyRegs(0, 0, 0, 0, 0, 0, 0);

    // Mispredict with icache miss; flush depth follows BR_STAGE
    doReset();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("mp_pcen", 32'(pcen_a), 32'h1);
    checkOutput("mp_en", 32'(en_a), 32'hF);
    checkOutput("mp_flush_br3", 32'(flush_a), 32'b0111);
    checkOutput("mp_flush_br2", 32'(flush_b), 32'b0011);
    tick();
    checkOutput("mp_fcnt", 32'(fcnt_a), 32'h1);
    checkOutput("mp_stall", 32'(stall_a), 32'h0);

    // Dcache miss masks a held mispredict for three cycles
    doReset();
    applyStimulus(1, 0, 1, 0, 1);
    checkOutput("miss_pcen", 32'(pcen_a), 32'h0);
    checkOutput("miss_en", 32'(en_a), 32'h0);
    checkOutput("miss_flush", 32'(flush_a), 32'h0);
    tick();
    tick();
    checkOutput("miss_en_c3", 32'(en_a), 32'h0);
    tick();
    checkOutput("miss_stall", 32'(stall_a), 32'h3);
    checkOutput("miss_fcnt", 32'(fcnt_a), 32'h0);
    applyStimulus(1, 1, 1, 0, 1);
    checkOutput("dhit_mp_pcen", 32'(pcen_a), 32'h1);
    checkOutput("dhit_mp_flush", 32'(flush_a), 32'b0111);
    tick();
    checkOutput("dhit_mp_fcnt", 32'(fcnt_a), 32'h1);
    checkOutput("dhit_stall", 32'(stall_a), 32'h3);

    // Halt together with mispredict: mispredict acts now, halt on the edge
    applyStimulus(1, 0, 0, 1, 1);
    checkOutput("hm_pcen", 32'(pcen_a), 32'h1);
    checkOutput("hm_flush", 32'(flush_a), 32'b0111);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("halt_halted", 32'(halted_a), 32'h1);
    checkOutput("halt_pcen", 32'(pcen_a), 32'h0);
    checkOutput("halt_en", 32'(en_a), 32'h0);
    checkOutput("halt_flush", 32'(flush_a), 32'h0);
    checkOutput("halt_fcnt", 32'(fcnt_a), 32'h2);
    tick();
    tick();
    tick();
    checkOutput("halt_sticky", 32'(halted_a), 32'h1);
    checkOutput("halt_stall_frozen", 32'(stall_a), 32'h3);

    // Asynchronous reset mid-cycle clears everything immediately
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("arst_halted", 32'(halted_a), 32'h0);
    checkOutput("arst_stall", 32'(stall_a), 32'h0);
    checkOutput("arst_fcnt", 32'(fcnt_a), 32'h0);
    checkOutput("arst_flush", 32'(flush_a), 32'hF);
    @(posedge CLK);
    #1;
    nRST = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("arst_run_pcen", 32'(pcen_a), 32'h1);

    // Icache miss bubbles; CNTW=4 counter saturates at 15
    doReset();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("imiss_pcen", 32'(pcen_a), 32'h0);
    checkOutput("imiss_en", 32'(en_a), 32'hF);
    checkOutput("imiss_flush", 32'(flush_a), 32'b0001);
    for (int i = 0; i < 20; i++) tick();
    checkOutput("sat_stall_b", 32'(stall_b), 32'hF);
    checkOutput("stall_a_20", 32'(stall_a), 32'd20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_p.md
Name: hazard_ctrl_p

Overview:
- Parametrised pipeline hazard controller for the 5-stage datapath; generalises the fixed hazard unit.
- Drives enable and flush for the four pipeline latches and for the PC.
- Adds a forwarding-aware stall mode, a configurable branch-resolve stage, a dcache-wait/halt state machine and saturating stall/flush performance counters.
- Sits beside the datapath; consumes cache handshakes and decode/execute register fields.

Parameters:
- REGW, 5, register index width.
- FWD_EN, 1, 1 = forwarding unit present (stall only on load-use); 0 = stall on any RAW against EX or MEM.
- BR_STAGE, 3, latch index whose output holds the resolved branch (1..3); latches below it are flushed on mispredict.
- CNTW, 16, perf counter width.

Ports:
- CLK  in  1  clock
- nRST  in  1  async active-low reset
- ihit  in  1  icache hit this cycle
- dhit  in  1  dcache hit this cycle
- dmemreq  in  1  MEM stage has a load/store outstanding
- halt  in  1  halt instruction at MEM/WB output
- id_rs, id_rt  in  REGW  source registers in decode
- ex_rd, mem_rd  in  REGW  destinations in EX, MEM
- ex_regWEN, mem_regWEN  in  1  destination writes
- ex_memread  in  1  EX instruction is a load
- mispredict  in  1  branch at BR_STAGE resolved opposite to prediction
- pcen  out  1  PC update enable
- latch_en  out  4  enables; bit0 IF/ID, 1 ID/EX, 2 EX/MEM, 3 MEM/WB
- latch_flush  out  4  synchronous clear of the same latches
- halted  out  1  sticky halt indicator
- stall_cnt  out  CNTW  stalled-cycle count
- flush_cnt  out  CNTW  mispredict count

Behaviour:
- States: RUN, MEMWAIT, HALTED. Reset state is RUN.
- Reset: halted=0, counters=0.
- While nRST is low: pcen=0, latch_en=0, latch_flush=4'hF.
- Transitions:
  - RUN->MEMWAIT when dmemreq&!dhit.
  - MEMWAIT->RUN on dhit.
  - RUN or MEMWAIT->HALTED when halt and no MEM wait that cycle.
  - HALTED is absorbing until reset.
- Combinational outputs, in priority order, highest first:
  1. HALTED: pcen=0, en=0, flush=0, halted=1.
  2. dmemreq&!dhit (any state): freeze everything; pcen=0, en=0, flush=0.
  3. mispredict: pcen=1 (PC loads target even if !ihit; in-flight fetch discarded); en=4'hF; flush bits [BR_STAGE-1:0]=1.
  4. Data hazard:
     - Hazard condition: (id_rs or id_rt) nonzero and equal to ex_rd, with FWD_EN=1 ? ex_memread : ex_regWEN.
     - FWD_EN=0 only: also a hazard when the same match holds against mem_rd&mem_regWEN.
     - Response: pcen=0, latch_en[0]=0, latch_en[3:1]=1, latch_flush[1]=1 (bubble into ID/EX).
  5. !ihit: pcen=0, latch_en=4'hF, latch_flush[0]=1 (bubble into IF/ID).
  6. Otherwise pcen=1, en=4'hF, flush=0.
- Register 0 never creates a hazard.
- FWD_EN=1 load-use costs exactly one stall cycle; back-to-back dependent loads stall one cycle each.
- Counters update on the rising edge:
  - stall_cnt +1 each cycle pcen=0 and state!=HALTED and nRST high.
  - flush_cnt +1 each cycle rule 3 applies.
  - Both saturate at 2^CNTW-1 (no wrap).
- Simultaneous events:
  - halt with mispredict → HALTED on next edge; the mispredict outputs apply this cycle.
  - mispredict during dcache miss is ignored until dhit; the source holds mispredict until then.
- Reset asserted mid-operation returns to RUN, clears counters and halted immediately (async).

Test Plan:
- FWD_EN=1, ex_memread=1, ex_rd=5, id_rs=5 → one cycle: pcen=0, latch_en=4'b1110, latch_flush=4'b0010; next cycle (bubble, ex_memread=0) pcen=1; stall_cnt=1.
- FWD_EN=0, mem_regWEN=1, mem_rd=7, id_rt=7 → stall; same with id_rt=0, rd=0 → no stall.
- BR_STAGE=3, mispredict=1, ihit=0 → pcen=1, latch_flush=4'b0111, flush_cnt increments; BR_STAGE=2 → latch_flush=4'b0011.
- dmemreq=1, dhit=0 for 3 cycles alongside mispredict=1 → en=0, pcen=0, stall_cnt=3, flush_cnt unchanged; dhit=1 → mispredict honoured.
- halt=1 → next cycle halted=1, all en=0, pcen=0 indefinitely; stall_cnt frozen; nRST pulse low → halted=0, counters=0.
- CNTW=4 with 20 !ihit cycles → stall_cnt saturates at 15.
